// File: rtl/grid_placer_eval_if.sv
// Bundles the run handshake, position preload/readback and edge-ROM signals of grid_placer_eval.
interface grid_placer_eval_if #(
  parameter int unsigned NODE_W = 8,
  parameter int unsigned COST_W = 32
);
  logic              start;
  logic              rand_place;
  logic [1:0]        mode;
  logic              seed_load;
  logic [31:0]       seed_in;
  logic              pos_wr;
  logic [NODE_W-1:0] pos_wr_addr;
  logic [NODE_W-1:0] pos_wr_x;
  logic [NODE_W-1:0] pos_wr_y;
  logic              edge_rd;
  logic [31:0]       edge_addr;
  logic [NODE_W-1:0] edge_a;
  logic [NODE_W-1:0] edge_b;
  logic [NODE_W-1:0] pos_rd_addr;
  logic [NODE_W-1:0] pos_x;
  logic [NODE_W-1:0] pos_y;
  logic              busy;
  logic              done;
  logic              fail;
  logic              bad_edge;
  logic [COST_W-1:0] cost;
  logic [COST_W-1:0] max_len;
  logic [31:0]       cycles;

  modport master (
    output start, rand_place, mode, seed_load, seed_in, pos_wr, pos_wr_addr, pos_wr_x, pos_wr_y,
           edge_a, edge_b, pos_rd_addr,
    input  edge_rd, edge_addr, pos_x, pos_y, busy, done, fail, bad_edge, cost, max_len, cycles
  );

  modport slave (
    input  start, rand_place, mode, seed_load, seed_in, pos_wr, pos_wr_addr, pos_wr_x, pos_wr_y,
           edge_a, edge_b, pos_rd_addr,
    output edge_rd, edge_addr, pos_x, pos_y, busy, done, fail, bad_edge, cost, max_len, cycles
  );
endinterface

// File: rtl/grid_placer_eval.sv
// Random/preloaded grid placement followed by edge-list wirelength evaluation.
// Define PLACER_CYCLE_COUNT_EN to build the run-length counter on the cycles output.
module grid_placer_eval #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned N_NODES   = 16,
  parameter int unsigned N_EDGES   = 32,
  parameter int unsigned NODE_W    = 8,
  parameter int unsigned MAX_TRIES = 64,
  parameter logic [31:0] SEED      = 32'hACE12F35,
  parameter int unsigned COST_W    = 32
) (
  input logic               clk,
  input logic               reset,
  grid_placer_eval_if.slave bus
);
  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned CELL_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned NIDX_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam logic [31:0] TAPS   = 32'h80200003;

  if (N_NODES > CELLS) begin : g_cfg_check
    $error("grid_placer_eval: N_NODES exceeds ROWS*COLS");
  end

  typedef enum logic [3:0] {
    StIdle, StClear, StGen, StTry, StEvalReq, StEvalWait, StEvalPos, StEvalAcc, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_nxt;
  logic [CELLS-1:0]  occ_q;
  logic [NODE_W-1:0] pos_x_q [N_NODES];
  logic [NODE_W-1:0] pos_y_q [N_NODES];
  logic [NODE_W-1:0] cand_x_q, cand_y_q;
  logic [CELL_W-1:0] cand_cell;
  logic              cand_hit;
  logic [31:0]       node_q, tries_q, clr_q, edge_idx_q;
  logic [1:0]        mode_q;
  logic [NODE_W-1:0] ea_q, eb_q, xa_q, ya_q, xb_q, yb_q;
  logic              a_ok, b_ok, rd_ok;
  logic              fail_q, bad_q;
  logic [COST_W-1:0] cost_q, max_q, len;
  logic [NODE_W-1:0] rd_x_q, rd_y_q;
  logic [NODE_W:0]   dx, dy;
  logic [NODE_W+1:0] len_w;
  logic [COST_W:0]   sum;

  assign lfsr_nxt  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
  assign cand_cell = CELL_W'(32'(cand_y_q) * COLS + 32'(cand_x_q));
  assign cand_hit  = occ_q[cand_cell];
  assign a_ok      = 32'(ea_q) < N_NODES;
  assign b_ok      = 32'(eb_q) < N_NODES;
  assign rd_ok     = 32'(bus.pos_rd_addr) < N_NODES;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (bus.start) state_d = bus.rand_place ? StClear : StEvalReq;
      StClear:    if (clr_q == CELLS - 1) state_d = StGen;
      StGen:      state_d = StTry;
      StTry: begin
        if (!cand_hit)                       state_d = (node_q == N_NODES - 1) ? StEvalReq : StGen;
        else if (tries_q + 1 == MAX_TRIES)   state_d = StDone;
        else                                 state_d = StGen;
      end
      StEvalReq:  state_d = (edge_idx_q == N_EDGES) ? StDone : StEvalWait;
      StEvalWait: state_d = StEvalPos;
      StEvalPos:  state_d = StEvalAcc;
      StEvalAcc:  state_d = StEvalReq;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    bus.edge_rd = 1'b0;
    unique case (state_q)
      StIdle:    bus.busy = 1'b0;
      StDone: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
      end
      StEvalReq: bus.edge_rd = (edge_idx_q != N_EDGES);
      default:   ;
    endcase
  end

  // Edge length at NODE_W+2 bits; mode 3 falls through to Manhattan.
  always_comb begin
    dx = (xa_q >= xb_q) ? ({1'b0, xa_q} - {1'b0, xb_q}) : ({1'b0, xb_q} - {1'b0, xa_q});
    dy = (ya_q >= yb_q) ? ({1'b0, ya_q} - {1'b0, yb_q}) : ({1'b0, yb_q} - {1'b0, ya_q});
    unique case (mode_q)
      2'd1:    len_w = (dx >= dy) ? {1'b0, dx} : {1'b0, dy};
      2'd2:    len_w = {1'b0, dx >> 1} + {1'b0, dy >> 1}
                       + (NODE_W + 2)'(dx[0]) + (NODE_W + 2)'(dy[0]);
      default: len_w = {1'b0, dx} + {1'b0, dy};
    endcase
    len = COST_W'(len_w);
    sum = {1'b0, cost_q} + {1'b0, len};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= SEED;
      occ_q      <= '0;
      for (int i = 0; i < N_NODES; i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
      end
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      node_q     <= '0;
      tries_q    <= '0;
      clr_q      <= '0;
      edge_idx_q <= '0;
      mode_q     <= '0;
      ea_q       <= '0;
      eb_q       <= '0;
      xa_q       <= '0;
      ya_q       <= '0;
      xb_q       <= '0;
      yb_q       <= '0;
      fail_q     <= 1'b0;
      bad_q      <= 1'b0;
      cost_q     <= '0;
      max_q      <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
    end else begin
      rd_x_q <= rd_ok ? pos_x_q[bus.pos_rd_addr[NIDX_W-1:0]] : '0;
      rd_y_q <= rd_ok ? pos_y_q[bus.pos_rd_addr[NIDX_W-1:0]] : '0;
      unique case (state_q)
        StIdle: begin
          if (bus.seed_load) lfsr_q <= (bus.seed_in == '0) ? SEED : bus.seed_in;
          if (bus.pos_wr && (32'(bus.pos_wr_addr) < N_NODES)) begin
            pos_x_q[bus.pos_wr_addr[NIDX_W-1:0]] <= bus.pos_wr_x;
            pos_y_q[bus.pos_wr_addr[NIDX_W-1:0]] <= bus.pos_wr_y;
          end
          if (bus.start) begin
            mode_q     <= bus.mode;
            fail_q     <= 1'b0;
            bad_q      <= 1'b0;
            cost_q     <= '0;
            max_q      <= '0;
            node_q     <= '0;
            tries_q    <= '0;
            clr_q      <= '0;
            edge_idx_q <= '0;
          end
        end
        StClear: begin
          occ_q[clr_q[CELL_W-1:0]] <= 1'b0;
          clr_q                    <= clr_q + 32'd1;
        end
        StGen: begin
          lfsr_q   <= lfsr_nxt;
          cand_x_q <= NODE_W'(32'(lfsr_nxt[15:0]) % COLS);
          cand_y_q <= NODE_W'(32'(lfsr_nxt[31:16]) % ROWS);
        end
        StTry: begin
          if (!cand_hit) begin
            occ_q[cand_cell]              <= 1'b1;
            pos_x_q[node_q[NIDX_W-1:0]] <= cand_x_q;
            pos_y_q[node_q[NIDX_W-1:0]] <= cand_y_q;
            tries_q                       <= '0;
            node_q                        <= node_q + 32'd1;
          end else begin
            tries_q <= tries_q + 32'd1;
            if (tries_q + 1 == MAX_TRIES) begin
              fail_q <= 1'b1;
              cost_q <= '1;
              max_q  <= '0;
            end
          end
        end
        StEvalWait: begin
          ea_q <= bus.edge_a;
          eb_q <= bus.edge_b;
        end
        StEvalPos: begin
          xa_q <= a_ok ? pos_x_q[ea_q[NIDX_W-1:0]] : '0;
          ya_q <= a_ok ? pos_y_q[ea_q[NIDX_W-1:0]] : '0;
          xb_q <= b_ok ? pos_x_q[eb_q[NIDX_W-1:0]] : '0;
          yb_q <= b_ok ? pos_y_q[eb_q[NIDX_W-1:0]] : '0;
        end
        StEvalAcc: begin
          if (!(a_ok && b_ok)) begin
            bad_q <= 1'b1;
          end else begin
            cost_q <= sum[COST_W] ? '1 : sum[COST_W-1:0];
            if (len > max_q) max_q <= len;
          end
          edge_idx_q <= edge_idx_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.edge_addr = edge_idx_q;
  assign bus.pos_x     = rd_x_q;
  assign bus.pos_y     = rd_y_q;
  assign bus.fail      = fail_q;
  assign bus.bad_edge  = bad_q;
  assign bus.cost      = cost_q;
  assign bus.max_len   = max_q;

`ifdef PLACER_CYCLE_COUNT_EN
  logic [31:0] cycles_q;

  // Starts at 1 so the accepting cycle is included in the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles_q <= '0;
    end else if (state_q == StIdle) begin
      if (bus.start) cycles_q <= 32'd1;
    end else if (cycles_q != '1) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign bus.cycles = cycles_q;
`else
  assign bus.cycles = '0;
`endif
endmodule

// File: doc/grid_placer_eval.md
Name: grid_placer_eval

Overview:
- Parametrised successor of the single-grid random placer.
- Places N_NODES nodes on a ROWS x COLS grid using a 32-bit LFSR with collision retry, or takes a preloaded placement.
- Then walks an external edge-list ROM and reports total and maximum wirelength under a selectable metric: Manhattan, Chebyshev or 1-hop.
- Sits between the edge-list ROMs and the placement driver/testbench; a start/busy/done handshake replaces free-running operation.

Parameters:
ROWS, 8, grid rows (y range 0..ROWS-1)
COLS, 8, grid columns (x range 0..COLS-1)
N_NODES, 16, node count; elaboration error if N_NODES > ROWS*COLS
N_EDGES, 32, edges read from ROM, addresses 0..N_EDGES-1
NODE_W, 8, width of node indices and coordinates
MAX_TRIES, 64, candidate attempts per node before failure
SEED, 32'hACE12F35, LFSR value used at reset and when seed_in==0
COST_W, 32, width of cost accumulator

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin run; sampled only in IDLE
rand_place  in  1  1: random placement then evaluate; 0: evaluate preloaded positions; sampled with start
mode  in  2  0 Manhattan, 1 Chebyshev, 2 1-hop (ceil(dx/2)+ceil(dy/2)), 3 treated as 0; sampled with start
seed_load  in  1  in IDLE, load seed_in into LFSR
seed_in  in  32  new seed
pos_wr  in  1  preload write, honoured only in IDLE
pos_wr_addr  in  NODE_W  node index
pos_wr_x, pos_wr_y  in  NODE_W  coordinates
edge_rd  out  1  ROM read strobe
edge_addr  out  32  ROM address
edge_a, edge_b  in  NODE_W  ROM data, valid 1 cycle after edge_rd
pos_rd_addr  in  NODE_W  readback index
pos_x, pos_y  out  NODE_W  readback, registered, 1-cycle latency
busy  out  1  high from cycle after start until done
done  out  1  one-cycle pulse at end of run
fail  out  1  sticky until next start; placement gave up
bad_edge  out  1  sticky until next start; edge endpoint >= N_NODES seen
cost  out  COST_W  total wirelength, held until next start
max_len  out  COST_W  largest single edge length
cycles  out  32  run length (optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR=SEED, positions and grid occupancy cleared.
- Reset mid-run aborts with no done pulse.
- States:
  - IDLE: start → CLEAR when rand_place=1, else → EVAL_REQ. start while busy is ignored.
  - CLEAR: clears the occupancy bitmap one cell per cycle, ROWS*COLS cycles → GEN.
  - GEN: steps the LFSR once. Galois form, taps 32'h80200003; shift right, XOR taps when bit 0 was 1. Candidate x = lfsr[15:0] % COLS, y = lfsr[31:16] % ROWS → TRY.
  - TRY: reads occupancy of cell y*COLS+x.
    - Free: mark cell, write the node position, reset the tries count. Next node → GEN; after the last node → EVAL_REQ.
    - Occupied: tries+1. If tries reaches MAX_TRIES: fail=1, cost=all ones, max_len=0 → DONE. Otherwise → GEN.
  - EVAL_REQ: edge_rd=1 with edge_addr=i → EVAL_WAIT → EVAL_POS, which reads both positions in the same cycle → EVAL_ACC.
  - EVAL_ACC:
    - Computes dx=|xa-xb| and dy=|ya-yb| at NODE_W+1 bits.
    - Length: Manhattan dx+dy; Chebyshev max(dx,dy); 1-hop (dx>>1)+dx[0]+(dy>>1)+dy[0].
    - cost += len, saturating at all ones. max_len = max(max_len, len).
    - If an endpoint >= N_NODES, the edge is skipped and bad_edge=1.
    - i+1; when i==N_EDGES → DONE.
  - DONE: done=1 for one cycle → IDLE; busy drops in the same cycle.
- N_EDGES=0: cost=0, done 3 cycles after start.
- The seed persists across runs (no reseed per run), so repeated runs give new placements.

Optional Feature:
- PLACER_CYCLE_COUNT_EN defined: cycles counts clk edges from the cycle start is accepted through the done cycle inclusive, saturating, held until next start.
- Undefined: cycles tied to 0 and no counter logic exists.

Test Plan:
- ROWS=1, COLS=4, N=4; preload nodes 0..3 at x=0..3; edges (0,1),(0,3),(1,2); rand_place=0, mode 0 → cost=5, max_len=3, done after 3 edges, fail=0.
- Same preload, x/y diagonal: nodes at (0,0),(3,1); edge (0,1) → mode0 cost=4, mode1 cost=3, mode2 cost=3.
- ROWS=COLS=2, N=4, rand_place=1, seed 32'h1 → all four cells occupied exactly once, positions distinct, fail=0; rerun with same seed_load gives identical positions.
- ROWS=COLS=2, N=4, MAX_TRIES=1 → fail=1, cost=32'hFFFFFFFF, done pulse exactly 1 cycle.
- Edge with edge_a=N_NODES → bad_edge=1, edge excluded from cost; start asserted during busy has no effect; reset mid-EVAL → outputs 0, no done.
- With PLACER_CYCLE_COUNT_EN and N_EDGES=0, rand_place=0 → cycles=3.
